// File: rtl/gate_bist_pkg.sv
// Shared types, mask indices and the golden gate model for the CMOS gate BIST.
package gate_bist_pkg;

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SETTLE, S_CHECK, S_DONE} bist_state_e;

    localparam int M_INV   = 0;
    localparam int M_NAND  = 1;
    localparam int M_NOR   = 2;
    localparam int M_XOR   = 3;
    localparam int M_XNOR  = 4;
    localparam int N_GATES = 5;

    // Feedback taps 7,5,4,3: maximal-length 8-bit sequence.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [N_GATES-1:0] golden(input logic in, input logic a, input logic b);
        logic [N_GATES-1:0] g;
        g[M_INV]  = ~in;
        g[M_NAND] = ~(a & b);
        g[M_NOR]  = ~(a | b);
        g[M_XOR]  = a ^ b;
        g[M_XNOR] = ~(a ^ b);
        return g;
    endfunction

endpackage

// File: rtl/gate_bist_if.sv
// Control, stimulus and result bundle between the BIST controller and its wrapper.
interface gate_bist_if #(parameter int CNT_W = 8);
    logic             start;
    logic             stim_in, stim_a, stim_b;
    logic             dut_inv, dut_nand, dut_nor, dut_xor, dut_xnor;
    logic             busy, done, pass;
    logic [CNT_W-1:0] err_count;
    logic [7:0]       first_err_vec;
    logic [4:0]       first_err_mask;

    modport master (
        output start, dut_inv, dut_nand, dut_nor, dut_xor, dut_xnor,
        input  stim_in, stim_a, stim_b, busy, done, pass,
               err_count, first_err_vec, first_err_mask
    );

    modport slave (
        input  start, dut_inv, dut_nand, dut_nor, dut_xor, dut_xnor,
        output stim_in, stim_a, stim_b, busy, done, pass,
               err_count, first_err_vec, first_err_mask
    );
endinterface

// File: rtl/bist_lfsr8.sv
// 8-bit Fibonacci LFSR (shift left) with synchronous load; only the low OUT_W bits are exported.
module bist_lfsr8 import gate_bist_pkg::*; #(
    parameter logic [7:0] RST_SEED = 8'h01,
    parameter int         OUT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [7:0]       seed,
    input  logic             advance,
    output logic [OUT_W-1:0] q
);
    logic [7:0] r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r <= RST_SEED;
        else if (load)    r <= seed;
        else if (advance) r <= {r[6:0], ^(r & LFSR_TAPS)};
    end

    assign q = r[OUT_W-1:0];
endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: drives LFSR stimulus into the five gates, checks them against the
// golden model and accumulates a saturating error count plus first-failure capture.
module gate_bist_ctrl import gate_bist_pkg::*; #(
    parameter int         NUM_VECTORS   = 16,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] LFSR_SEED     = 8'h01,
    parameter int         CNT_W         = 8
) (
    input logic       clk,
    input logic       rst_n,
    gate_bist_if.slave bus
);
    localparam logic [7:0]       SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0]       LAST_IDX = 8'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;
    localparam int               SW       = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0]    SET_LAST = SW'(SETTLE_CYCLES - 1);

    bist_state_e          state;
    logic [7:0]           vec_idx;
    logic [SW-1:0]        settle_cnt;
    logic                 stim_in_q, stim_a_q, stim_b_q;
    logic                 busy_q, done_q, pass_q;
    logic [CNT_W-1:0]     err_q;
    logic [7:0]           fev_q;
    logic [N_GATES-1:0]   fem_q;
    logic [2:0]           lfsr_q;
    logic [N_GATES-1:0]   dut_v, exp_v, mism;
    logic                 any_mism, accept;

    assign accept = (state == S_IDLE || state == S_DONE) && bus.start;

    bist_lfsr8 #(.RST_SEED(SEED), .OUT_W(3)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .seed    (SEED),
        .advance (state == S_CHECK),
        .q       (lfsr_q)
    );

    assign dut_v = {bus.dut_xnor, bus.dut_xor, bus.dut_nor, bus.dut_nand, bus.dut_inv};
    assign exp_v = golden(stim_in_q, stim_a_q, stim_b_q);

    // Case inequality so an undriven or contended gate output is reported, not masked.
    always_comb begin
        mism = '0;
        for (int i = 0; i < N_GATES; i++) mism[i] = (dut_v[i] !== exp_v[i]);
    end
    assign any_mism = |mism;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec_idx    <= '0;
            settle_cnt <= '0;
            stim_in_q  <= 1'b0;
            stim_a_q   <= 1'b0;
            stim_b_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            fev_q      <= '0;
            fem_q      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (bus.start) begin
                    state   <= S_APPLY;
                    vec_idx <= '0;
                    err_q   <= '0;
                    fev_q   <= '0;
                    fem_q   <= '0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                    busy_q  <= 1'b1;
                end
                S_APPLY: begin
                    {stim_b_q, stim_a_q, stim_in_q} <= lfsr_q;
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_LAST) state <= S_CHECK;
                    else settle_cnt <= settle_cnt + SW'(1);
                end
                S_CHECK: begin
                    if (any_mism) begin
                        if (err_q != ERR_MAX) err_q <= err_q + CNT_W'(1);
                        // A zero count means no earlier vector has failed this run.
                        if (err_q == '0) begin
                            fev_q <= vec_idx;
                            fem_q <= mism;
                        end
                    end
                    vec_idx <= vec_idx + 8'd1;
                    if (vec_idx == LAST_IDX) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0) && !any_mism;
                    end else begin
                        state <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.stim_in        = stim_in_q;
    assign bus.stim_a         = stim_a_q;
    assign bus.stim_b         = stim_b_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_q;
    assign bus.first_err_vec  = fev_q;
    assign bus.first_err_mask = fem_q;
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench: gate models with injectable faults, stimulus/result scoreboard queues.
module tb_gate_bist_ctrl;
    typedef struct {
        logic [7:0] err;
        logic [7:0] fev;
        logic [4:0] fem;
        logic       pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_bist_if #(.CNT_W(8)) bif0 ();
    gate_bist_if #(.CNT_W(2)) bif1 ();

    gate_bist_ctrl #(.NUM_VECTORS(16), .SETTLE_CYCLES(2), .LFSR_SEED(8'h01), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bif0)
    );
    gate_bist_ctrl #(.NUM_VECTORS(8), .SETTLE_CYCLES(2), .LFSR_SEED(8'h01), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bif1)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    int   fault    = 0;
    logic xprobe;
    logic four_state;
    assign xprobe = 1'bx;

    // Expected LFSR states for the default seed, worked out by hand from the tap equation.
    logic [7:0] tab [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E,
                             8'h1C, 8'h38, 8'h71, 8'hE2, 8'hC4, 8'h89, 8'h12, 8'h25};
    logic [2:0] stim_q [$];
    exp_t       res_q  [$];

    // fault 1: NAND stuck at 1; fault 2: inverter X (always-wrong level on a 2-state simulator).
    always_comb begin
        bif0.dut_inv  = ~bif0.stim_in;
        bif0.dut_nand = ~(bif0.stim_a & bif0.stim_b);
        bif0.dut_nor  = ~(bif0.stim_a | bif0.stim_b);
        bif0.dut_xor  = bif0.stim_a ^ bif0.stim_b;
        bif0.dut_xnor = ~(bif0.stim_a ^ bif0.stim_b);
        if (fault == 1) bif0.dut_nand = 1'b1;
        if (fault == 2) bif0.dut_inv = four_state ? 1'bx : bif0.stim_in;
    end

    // Second instance sees every gate output inverted.
    always_comb begin
        bif1.dut_inv  = bif1.stim_in;
        bif1.dut_nand = bif1.stim_a & bif1.stim_b;
        bif1.dut_nor  = bif1.stim_a | bif1.stim_b;
        bif1.dut_xor  = ~(bif1.stim_a ^ bif1.stim_b);
        bif1.dut_xnor = bif1.stim_a ^ bif1.stim_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_busy"}, 32'(bif0.busy), 0);
        chk({tag, "_done"}, 32'(bif0.done), 0);
        chk({tag, "_pass"}, 32'(bif0.pass), 0);
        chk({tag, "_err"},  32'(bif0.err_count), 0);
        chk({tag, "_fev"},  32'(bif0.first_err_vec), 0);
        chk({tag, "_fem"},  32'(bif0.first_err_mask), 0);
        chk({tag, "_stim"}, 32'({bif0.stim_b, bif0.stim_a, bif0.stim_in}), 0);
    endtask

    // One run on dut0. extra=1 pulses start twice mid-run; abort_at>0 pulls reset at that cycle.
    task automatic run0(input string tag, input bit extra, input int abort_at, output int cyc);
        exp_t e;
        logic [2:0] s;
        for (int i = 0; i < 16; i++) stim_q.push_back(tab[i][2:0]);
        @(negedge clk) bif0.start = 1'b1;
        @(negedge clk) bif0.start = 1'b0;
        chk({tag, "_start_done"}, 32'(bif0.done), 0);
        chk({tag, "_start_pass"}, 32'(bif0.pass), 0);
        chk({tag, "_start_busy"}, 32'(bif0.busy), 1);
        cyc = 0;
        while (!bif0.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bif0.start = 1'b0;
            if (cyc % 4 == 2 && stim_q.size() > 0) begin
                s = stim_q.pop_front();
                chk({tag, "_stim"}, 32'({bif0.stim_b, bif0.stim_a, bif0.stim_in}), 32'(s));
            end
            if (extra && (cyc == 9 || cyc == 30)) bif0.start = 1'b1;
            if (abort_at != 0 && cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_zero0({tag, "_abort"});
                stim_q.delete();
                @(negedge clk) rst_n = 1'b1;
                break;
            end
        end
        bif0.start = 1'b0;
        if (abort_at == 0) begin
            chk({tag, "_stim_left"}, 32'(stim_q.size()), 0);
            e = res_q.pop_front();
            chk({tag, "_latency"}, 32'(cyc), 64);
            chk({tag, "_busy_end"}, 32'(bif0.busy), 0);
            chk({tag, "_err"},  32'(bif0.err_count), 32'(e.err));
            chk({tag, "_fev"},  32'(bif0.first_err_vec), 32'(e.fev));
            chk({tag, "_fem"},  32'(bif0.first_err_mask), 32'(e.fem));
            chk({tag, "_pass"}, 32'(bif0.pass), 32'(e.pass));
        end
    endtask

    initial begin
        int cyc;
        four_state = $isunknown(xprobe);
        bif0.start = 1'b0;
        bif1.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero0("reset");
        chk("reset_dut1_err", 32'(bif1.err_count), 0);
        chk("reset_dut1_done", 32'(bif1.done), 0);
        @(negedge clk) rst_n = 1'b1;

        fault = 0;
        res_q.push_back('{err: 8'd0, fev: 8'd0, fem: 5'b00000, pass: 1'b1});
        run0("clean", 1'b0, 0, cyc);

        res_q.push_back('{err: 8'd0, fev: 8'd0, fem: 5'b00000, pass: 1'b1});
        run0("busy_start", 1'b1, 0, cyc);

        fault = 1;
        res_q.push_back('{err: 8'd2, fev: 8'd6, fem: 5'b00010, pass: 1'b0});
        run0("nand_stuck", 1'b0, 0, cyc);

        fault = 2;
        res_q.push_back('{err: 8'd16, fev: 8'd0, fem: 5'b00001, pass: 1'b0});
        run0("inv_x", 1'b0, 0, cyc);

        fault = 0;
        run0("abort", 1'b0, 22, cyc);
        res_q.push_back('{err: 8'd0, fev: 8'd0, fem: 5'b00000, pass: 1'b1});
        run0("after_abort", 1'b0, 0, cyc);

        @(negedge clk) bif1.start = 1'b1;
        @(negedge clk) bif1.start = 1'b0;
        chk("sat_busy", 32'(bif1.busy), 1);
        cyc = 0;
        while (!bif1.done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("sat_latency", 32'(cyc), 32);
        chk("sat_err",  32'(bif1.err_count), 3);
        chk("sat_pass", 32'(bif1.pass), 0);
        chk("sat_fev",  32'(bif1.first_err_vec), 0);
        chk("sat_fem",  32'(bif1.first_err_mask), 32'h1F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/gate_bist_ctrl.md
Name: gate_bist_ctrl

Overview:
Synthesizable built-in self-test controller for the switch-level CMOS gate models (inverter, NAND, NOR, XOR, XNOR). It generates the pseudo-random stimulus and checks the five gate outputs against golden Boolean results. It also counts mismatches and reports pass/fail. It sits beside the gate instances in a BIST wrapper and replaces the software stimulus/checker loop with clocked hardware.

Parameters:
NUM_VECTORS, 16, number of stimulus vectors per run (1..255)
SETTLE_CYCLES, 2, clock cycles the stimulus is held before outputs are sampled (>=1)
LFSR_SEED, 8'h01, LFSR load value at start; 8'h00 is replaced by 8'h01
CNT_W, 8, width of the error counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a run; sampled in IDLE or DONE only
stim_in  output  1  inverter input drive
stim_a  output  1  two-input gate input A drive
stim_b  output  1  two-input gate input B drive
dut_inv  input  1  inverter output under test
dut_nand  input  1  NAND output under test
dut_nor  input  1  NOR output under test
dut_xor  input  1  XOR output under test
dut_xnor  input  1  XNOR output under test
busy  output  1  high from the first APPLY through the last CHECK
done  output  1  high in DONE, sticky until the next start
pass  output  1  valid when done; 1 iff err_count==0
err_count  output  CNT_W  vectors with >=1 mismatch, saturating
first_err_vec  output  8  index of the first failing vector
first_err_mask  output  5  mismatch bits of the first failing vector, {xnor,xor,nor,nand,inv}

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0; FSM in IDLE; LFSR = LFSR_SEED; vector index = 0.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE, start=1: load the LFSR with the seed, clear err_count, first_err_*, done and pass. Next state is APPLY.
- APPLY (1 cycle): registered outputs take stim_in=lfsr[0], stim_a=lfsr[1], stim_b=lfsr[2]. The settle counter is cleared. Next state is SETTLE.
- SETTLE: hold for SETTLE_CYCLES cycles, then go to CHECK.
- CHECK (1 cycle): compare the dut_* inputs against the golden values computed from the registered stimulus: ~in, ~(a&b), ~(a|b), a^b, ~(a^b).
- Comparison uses 4-state inequality, so X or Z on a dut_* input counts as a mismatch.
- Any mismatch increments err_count, saturating at 2^CNT_W-1.
- On the first failing vector only, capture first_err_vec = vector index and first_err_mask = per-gate mismatch bits.
- After the compare, advance the LFSR and increment the index. Go to APPLY, or to DONE if index == NUM_VECTORS-1.
- LFSR: 8-bit Fibonacci, shift left. lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. Period 255.
- DONE: done=1, busy=0, pass=(err_count==0). Stimulus outputs hold their last values.
- Latency: NUM_VECTORS*(SETTLE_CYCLES+2) cycles from the start-accept edge to done rising. With default parameters this is 64 cycles.
- start while busy is ignored. start in DONE restarts the run.
- Reset mid-run aborts immediately to the reset values. There is no partial result.

Decomposition:
- Package gate_bist_pkg holds:
  - state enum
  - mask bit index constants (INV=0, NAND=1, NOR=2, XOR=3, XNOR=4)
  - LFSR tap constant
  - function golden(in,a,b) returning the 5-bit expected vector
- Sub-module bist_lfsr8 (ports clk, rst_n, load, seed, advance, q) holds the LFSR. The FSM, compare and counters stay in gate_bist_ctrl.

Test Plan:
1. Defaults with correct gates connected; pulse start:
   - stimulus sequence begins {b,a,in} = 001, 010, 100
   - done rises exactly 64 cycles after start
   - pass=1, err_count=0
2. dut_nand tied to 1 with correct gates elsewhere:
   - err_count equals the number of vectors with a=b=1
   - first_err_mask = 5'b00010
   - first_err_vec = index of the first a=b=1 vector
3. dut_inv tied to X:
   - every vector fails; err_count = 16
   - first_err_vec = 0, first_err_mask = 5'b00001, pass=0
4. CNT_W=2, NUM_VECTORS=8, all outputs inverted:
   - err_count saturates at 3; pass=0
5. rst_n asserted low during SETTLE of vector 5:
   - all outputs 0 immediately, FSM in IDLE
   - a new start reproduces the scenario 1 sequence from 001
6. Extra start pulses during busy:
   - no effect; done still at cycle 64
   - a start in DONE clears done/pass and reruns the identical sequence
